// File: rtl/constants_pkg.sv
// Shared command encoding for the alu_registers command bus.
// No logic; type definitions only.
// Not applicable (no handshake).
package constants_pkg;

    typedef enum logic [1:0] {
        REG_READ  = 2'd0,
        REG_WRITE = 2'd1,
        ADD       = 2'd2
    } ALUOp;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the instruction-fetch handshake and the alu_registers command bus.
// Pure wiring, zero latency.
// Fetch uses req/valid: requester holds req and address until valid is seen.
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic                 instr_req;
    logic [PC_W-1:0]      instr_addr;
    logic                 instr_valid;
    logic [15:0]          instr_data;
    logic [2:0]           addr_a;
    logic [2:0]           addr_b;
    logic [2:0]           addr_r;
    logic [7:0]           data_in;
    constants_pkg::ALUOp  op;

    // Sequencer side: issues fetches and drives the register-file commands.
    modport master (
        output instr_req, instr_addr, addr_a, addr_b, addr_r, data_in, op,
        input  instr_valid, instr_data
    );

    // Memory / register-file side.
    modport slave (
        input  instr_req, instr_addr, addr_a, addr_b, addr_r, data_in, op,
        output instr_valid, instr_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer driving alu_registers from a 16-bit program; macro ALU_SEQ_ILLEGAL_HALT_EN makes illegal opcodes halt.
// Latency: LOADI 4 cycles, ADD 3+ADD_CYCLES, NOP/JMP 3 (zero-wait memory); all outputs registered.
// Backpressure: FETCH holds instr_req/instr_addr until instr_valid; run low parks the FSM in IDLE after the current instruction.
module alu_sequencer #(
    parameter int PC_W       = 8,
    parameter int ADD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            run,
    alu_sequencer_if.master bus,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);
    import constants_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    localparam logic [3:0] OPC_NOP   = 4'h0;
    localparam logic [3:0] OPC_LOADI = 4'h1;
    localparam logic [3:0] OPC_ADD   = 4'h2;
    localparam logic [3:0] OPC_JMP   = 4'h3;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    // An ADD is always held for at least one cycle.
    localparam int              ADD_HOLD = (ADD_CYCLES < 1) ? 1 : ADD_CYCLES;
    localparam int              CNT_W    = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_HOLD - 1);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              instr_req_q, instr_req_d;
    logic [2:0]        addr_a_q, addr_a_d;
    logic [2:0]        addr_b_q, addr_b_d;
    logic [2:0]        addr_r_q, addr_r_d;
    logic [7:0]        data_in_q, data_in_d;
    ALUOp              op_q, op_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    // Instruction fields, always taken from the latched instruction.
    logic [3:0]        opc;
    logic [2:0]        f_rd, f_ra, f_rb;
    logic [7:0]        f_imm;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   jmp_target;
    logic              opc_legal;

    assign opc        = ir_q[15:12];
    assign f_rd       = ir_q[11:9];
    assign f_ra       = ir_q[8:6];
    assign f_rb       = ir_q[5:3];
    assign f_imm      = ir_q[7:0];
    assign pc_inc     = pc_q + PC_W'(1);
    assign jmp_target = PC_W'(f_imm);
    assign opc_legal  = (opc == OPC_NOP) || (opc == OPC_LOADI) || (opc == OPC_ADD) ||
                        (opc == OPC_JMP) || (opc == OPC_HALT);

    // State register and all output/datapath flops; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            cnt_q       <= '0;
            instr_req_q <= 1'b0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_r_q    <= '0;
            data_in_q   <= '0;
            op_q        <= REG_READ;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            instr_req_q <= instr_req_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_r_q    <= addr_r_d;
            data_in_q   <= data_in_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state logic: sequencing, PC update, instruction latch and ADD hold counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.instr_valid) begin
                    ir_d    = bus.instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d = '0;
                case (opc)
                    OPC_NOP: begin
                        pc_d    = pc_inc;
                        state_d = S_IDLE;
                    end
                    OPC_LOADI, OPC_ADD: begin
                        state_d = S_EXECUTE;
                    end
                    OPC_JMP: begin
                        pc_d    = jmp_target;
                        state_d = S_IDLE;
                    end
                    OPC_HALT: begin
                        state_d = S_HALTED;
                    end
                    default: begin
`ifdef ALU_SEQ_ILLEGAL_HALT_EN
                        state_d = S_HALTED;
`else
                        pc_d    = pc_inc;
                        state_d = S_IDLE;
`endif
                    end
                endcase
            end
            S_EXECUTE: begin
                if ((opc != OPC_ADD) || (cnt_q == CNT_LAST)) begin
                    pc_d    = pc_inc;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: registered outputs follow the state being entered, so they line up with it.
    always_comb begin
        instr_req_d = (state_d == S_FETCH);
        busy_d      = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXECUTE);
        halted_d    = halted_q || (state_d == S_HALTED);
        illegal_d   = illegal_q || ((state_q == S_DECODE) && !opc_legal);
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_r_d    = addr_r_q;
        data_in_d   = data_in_q;
        op_d        = REG_READ;
        // Operand fields are captured once, on the way out of DECODE.
        if ((state_q == S_DECODE) && (state_d == S_EXECUTE)) begin
            if (opc == OPC_ADD) begin
                addr_a_d = f_ra;
                addr_b_d = f_rb;
                addr_r_d = f_rd;
            end else begin
                addr_a_d  = f_rd;
                data_in_d = f_imm;
            end
        end
        if (state_d == S_EXECUTE) begin
            op_d = (opc == OPC_ADD) ? ADD : REG_WRITE;
        end
    end

    assign bus.instr_req  = instr_req_q;
    assign bus.instr_addr = pc_q;
    assign bus.addr_a     = addr_a_q;
    assign bus.addr_b     = addr_b_q;
    assign bus.addr_r     = addr_r_q;
    assign bus.data_in    = data_in_q;
    assign bus.op         = op_q;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign illegal        = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: an instruction-level model predicts fetches and register-file commands.
// Memory responder supports per-address wait states; a small register file stands in for alu_registers.
// A monitor pops expectations whenever the DUT fetches or issues a non-read command.
module tb_alu_sequencer;
    import constants_pkg::*;

    localparam int PC_W = 8;
    localparam int AC   = 2;
    localparam int MEMN = 1 << PC_W;

    typedef struct {
        int kind;   // 0 fetch, 1 register write, 2 add
        int addr;
        int a;
        int b;
        int r;
        int d;
        int gap;    // expected cycles since previous fetch, -1 if unchecked
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run_en = 1'b0;
    logic run;
    logic busy, halted, illegal;
    int   stop_after = 100000;
    int   fetch_cnt = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [15:0] mem [MEMN];
    int          stall_tbl [MEMN];
    logic [7:0]  rf [8];
    ev_t         expq [$];

    alu_sequencer_if #(.PC_W(PC_W)) bus ();

    alu_sequencer #(.PC_W(PC_W), .ADD_CYCLES(AC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .bus     (bus),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal)
    );

    assign run = run_en & (fetch_cnt < stop_after);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for alu_registers.
    always @(posedge clk) begin
        if (bus.op == REG_WRITE) rf[bus.addr_a] <= bus.data_in;
        else if (bus.op == ADD)  rf[bus.addr_r] <= rf[bus.addr_a] + rf[bus.addr_b];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory: waits stall_tbl[addr] cycles per request, random junk on valid when idle.
    initial begin
        bit prev_req;
        int wait_left;
        logic [15:0] junk;
        prev_req = 1'b0;
        wait_left = 0;
        bus.instr_valid = 1'b0;
        bus.instr_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            junk = 16'($urandom);
            if (!reset_n) begin
                prev_req = 1'b0;
                bus.instr_valid = 1'b0;
            end else if (bus.instr_req) begin
                if (!prev_req) wait_left = stall_tbl[bus.instr_addr];
                if (wait_left > 0) begin
                    bus.instr_valid = 1'b0;
                    bus.instr_data  = junk;
                    wait_left--;
                end else begin
                    bus.instr_valid = 1'b1;
                    bus.instr_data  = mem[bus.instr_addr];
                end
                prev_req = 1'b1;
            end else begin
                bus.instr_valid = ($urandom_range(0, 3) == 0);
                bus.instr_data  = junk;
                prev_req = 1'b0;
            end
        end
    end

    // Monitor: compares every fetch and every non-read command against the queue head.
    initial begin
        int last_fetch;
        int req_addr;
        ev_t e;
        last_fetch = -1;
        req_addr = -1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                expq.delete();
                fetch_cnt = 0;
                last_fetch = -1;
                req_addr = -1;
                continue;
            end
            if (bus.instr_req && req_addr < 0) req_addr = int'(bus.instr_addr);
            if (bus.instr_req && bus.instr_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_fetch_addr", int'(bus.instr_addr), -1);
                end else begin
                    e = expq.pop_front();
                    chk("event_kind_fetch", 0, e.kind);
                    if (e.kind == 0) begin
                        chk("fetch_addr", int'(bus.instr_addr), e.addr);
                        chk("fetch_addr_stable", req_addr, e.addr);
                        if (e.gap >= 0 && last_fetch >= 0)
                            chk("fetch_spacing", cyc - last_fetch, e.gap);
                    end
                end
                last_fetch = cyc;
                fetch_cnt++;
                req_addr = -1;
            end
            if (bus.op != REG_READ) begin
                chk("busy_during_op", int'(busy), 1);
                if (expq.size() == 0) begin
                    chk("unexpected_op", int'(bus.op), int'(REG_READ));
                end else begin
                    e = expq.pop_front();
                    chk("event_kind_op", (bus.op == ADD) ? 2 : 1, e.kind);
                    if (e.kind == 1 && bus.op == REG_WRITE) begin
                        chk("write_addr_a", int'(bus.addr_a), e.a);
                        chk("write_data", int'(bus.data_in), e.d);
                    end else if (e.kind == 2 && bus.op == ADD) begin
                        chk("add_addr_a", int'(bus.addr_a), e.a);
                        chk("add_addr_b", int'(bus.addr_b), e.b);
                        chk("add_addr_r", int'(bus.addr_r), e.r);
                    end
                end
            end
        end
    end

    // Instruction-level reference: walks the program and queues the fetches/commands it implies.
    task automatic model(input int max_instr, output bit h, output bit il, output int nf);
        int pc;
        int prevlen;
        int opc;
        logic [15:0] ins;
        ev_t e;
        pc = 0;
        prevlen = -1;
        h = 1'b0;
        il = 1'b0;
        nf = 0;
        for (int k = 0; k < max_instr && !h; k++) begin
            ins = mem[pc];
            opc = int'(ins[15:12]);
            e = '{kind: 0, addr: pc, a: 0, b: 0, r: 0, d: 0,
                  gap: (prevlen < 0) ? -1 : prevlen + stall_tbl[pc]};
            expq.push_back(e);
            nf++;
            case (opc)
                0: begin pc = (pc + 1) % MEMN; prevlen = 3; end
                1: begin
                    e = '{kind: 1, addr: 0, a: int'(ins[11:9]), b: 0, r: 0, d: int'(ins[7:0]), gap: -1};
                    expq.push_back(e);
                    pc = (pc + 1) % MEMN;
                    prevlen = 4;
                end
                2: begin
                    e = '{kind: 2, addr: 0, a: int'(ins[8:6]), b: int'(ins[5:3]), r: int'(ins[11:9]), d: 0, gap: -1};
                    for (int j = 0; j < AC; j++) expq.push_back(e);
                    pc = (pc + 1) % MEMN;
                    prevlen = 3 + AC;
                end
                3: begin pc = int'(ins[7:0]) % MEMN; prevlen = 3; end
                15: h = 1'b1;
                default: begin
                    il = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_HALT_EN
                    h = 1'b1;
`else
                    pc = (pc + 1) % MEMN;
                    prevlen = 3;
`endif
                end
            endcase
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < MEMN; i++) begin
            mem[i] = 16'h0000;
            stall_tbl[i] = 0;
        end
    endtask

    // Reset, load expectations, run until the queue drains, then check the final flags.
    task automatic run_prog(input string nm, input int max_instr);
        bit h, il;
        int nf;
        int budget;
        run_en = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        model(max_instr, h, il, nf);
        stop_after = h ? 100000 : nf;
        #1;
        reset_n = 1'b1;
        run_en = 1'b1;
        budget = 0;
        while (expq.size() > 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        repeat (12) @(posedge clk);
        #1;
        chk({nm, "_pending_events"}, expq.size(), 0);
        chk({nm, "_halted"}, int'(halted), int'(h));
        chk({nm, "_illegal"}, int'(illegal), int'(il));
        chk({nm, "_busy_at_end"}, int'(busy), 0);
        chk({nm, "_req_at_end"}, int'(bus.instr_req), 0);
        run_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int n;
        clear_prog();
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", int'(bus.instr_req), 0);
        chk("rst_addr", int'(bus.instr_addr), 0);
        chk("rst_op", int'(bus.op), int'(REG_READ));
        chk("rst_addr_abr", int'({bus.addr_a, bus.addr_b, bus.addr_r}), 0);
        chk("rst_data_in", int'(bus.data_in), 0);
        chk("rst_flags", int'({busy, halted, illegal}), 0);

        // LOADI r0,0x42; LOADI r1,0x24; ADD r2,r0,r1; HALT, with a 3-cycle stall at 0x01.
        clear_prog();
        mem[0] = 16'h1042;
        mem[1] = 16'h1224;
        mem[2] = 16'h2408;
        mem[3] = 16'hF000;
        stall_tbl[1] = 3;
        run_prog("basic", 20);
        chk("basic_r2", int'(rf[2]), 8'h66);

        // JMP 0x02 at 0x05 loops back over NOPs.
        clear_prog();
        mem[5] = 16'h3002;
        run_prog("jmp", 12);

        // JMP 0xFF then NOP at 0xFF wraps PC to 0x00.
        clear_prog();
        mem[0]    = 16'h30FF;
        mem[8'hFF] = 16'h0000;
        run_prog("wrap", 5);

        // Undefined opcode 0x7 at 0x00 followed by HALT.
        clear_prog();
        mem[0] = 16'h7000;
        mem[1] = 16'hF000;
        run_prog("illegal", 5);

        // Reset during the second ADD cycle aborts at once; the rerun starts fetching at 0x00.
        clear_prog();
        mem[0] = 16'h2408;
        mem[1] = 16'hF000;
        run_en = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        begin
            bit h0, il0;
            int nf0;
            model(10, h0, il0, nf0);
        end
        stop_after = 100000;
        #1;
        reset_n = 1'b1;
        run_en = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge clk);
            if (bus.op == ADD) n++;
        end
        chk("abort_saw_two_add_cycles", n, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_op", int'(bus.op), int'(REG_READ));
        chk("abort_busy", int'(busy), 0);
        chk("abort_pc", int'(bus.instr_addr), 0);
        chk("abort_req", int'(bus.instr_req), 0);
        run_prog("after_abort", 10);

        // Random programs in 0x00..0x1F with random wait states.
        for (int p = 0; p < 6; p++) begin
            clear_prog();
            for (int a = 0; a < 32; a++) begin
                w = 16'($urandom);
                case ($urandom_range(0, 19))
                    0, 1, 2:          w[15:12] = 4'h0;
                    3, 4, 5, 6, 7:    w[15:12] = 4'h1;
                    8, 9, 10, 11, 12: w[15:12] = 4'h2;
                    13, 14: begin
                        w[15:12] = 4'h3;
                        w[7:0] = 8'($urandom_range(0, 31));
                    end
                    15, 16:           w[15:12] = 4'($urandom_range(4, 14));
                    17:               w[15:12] = 4'hF;
                    default:          w[15:12] = 4'h1;
                endcase
                mem[a] = w;
                stall_tbl[a] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_prog("random", 25);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
